// File: rtl/scope_acq.sv
// scope_acq: multi-channel triggered sample capture with pre-trigger history and readout.
// Define SCOPE_ACQ_HYST_EN to add trigger hysteresis (re-arm band of 4 codes around the level).
module scope_acq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int NCH    = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sample_en,
  input  logic [NCH*DATA_W-1:0] i_adc_d,
  input  logic                  i_start,
  input  logic [1:0]            i_trig_chan,
  input  logic                  i_trig_edge,
  input  logic [DATA_W-1:0]     i_trig_level,
  input  logic                  i_trig_mode,
  input  logic [CNT_W-1:0]      i_auto_timeout,
  input  logic [ADDR_W-1:0]     i_pretrig,
  input  logic                  i_rd_en,
  input  logic [1:0]            i_rd_chan,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_auto_trig,
  output logic [ADDR_W-1:0]     o_trig_addr,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_rd_valid
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_ARM  = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [NCH][DEPTH];
  logic [ADDR_W-1:0]   wp_q, wp_d, rp_q, rp_d, p_q, p_d, cnt_q, cnt_d, trig_addr_q, trig_addr_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;
  logic [DATA_W-1:0]   prev_q, prev_d, rd_data_q, rd_data_d;
  logic                prev_vld_q, prev_vld_d, auto_q, auto_d;
  logic                ready_q, ready_d, busy_q, busy_d, rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   cur_s, rd_word_s;
  logic [ADDR_W-1:0]   post_n_s;
  logic                acq_s, we_s, edge_s, fire_s, force_s;
`ifdef SCOPE_ACQ_HYST_EN
  localparam int HYST = 4;
  logic [DATA_W-1:0]   lo_s, hi_s;
  logic                beyond_s, hyst_ok_q, hyst_ok_d;
`endif

  // DEPTH-1-P post-trigger samples complete the buffer.
  assign post_n_s = ~p_q;
  assign acq_s    = (state_q == S_FILL) || (state_q == S_ARM) || (state_q == S_POST);
  assign we_s     = acq_s && i_sample_en && !i_start && !i_reset;

  // Trigger-source and readout channel select; out-of-range selects fall back to channel 0.
  always_comb begin
    cur_s     = i_adc_d[DATA_W-1:0];
    rd_word_s = mem_q[0][rp_q];
    for (int c = 1; c < NCH; c++) begin
      cur_s     = (int'(i_trig_chan) == c) ? i_adc_d[c*DATA_W +: DATA_W] : cur_s;
      rd_word_s = (int'(i_rd_chan) == c) ? mem_q[c][rp_q] : rd_word_s;
    end
  end

  // Edge detection and trigger qualification.
  always_comb begin
    edge_s = i_trig_edge ? ((prev_q > i_trig_level) && (cur_s <= i_trig_level))
                         : ((prev_q <= i_trig_level) && (cur_s > i_trig_level));
`ifdef SCOPE_ACQ_HYST_EN
    lo_s     = (i_trig_level < DATA_W'(HYST)) ? '0 : i_trig_level - DATA_W'(HYST);
    hi_s     = (i_trig_level > ({DATA_W{1'b1}} - DATA_W'(HYST))) ? '1 : i_trig_level + DATA_W'(HYST);
    beyond_s = i_trig_edge ? (cur_s > hi_s) : (cur_s < lo_s);
    fire_s   = prev_vld_q && edge_s && hyst_ok_q;
`else
    fire_s   = prev_vld_q && edge_s;
`endif
    force_s  = !i_trig_mode && (tcnt_q >= i_auto_timeout);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    trig_addr_d = trig_addr_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    auto_d      = auto_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
`ifdef SCOPE_ACQ_HYST_EN
    hyst_ok_d   = hyst_ok_q;
`endif
    if (i_start) begin
      state_d    = (i_pretrig == '0) ? S_ARM : S_FILL;
      wp_d       = '0;
      p_d        = i_pretrig;
      cnt_d      = '0;
      tcnt_d     = '0;
      prev_vld_d = 1'b0;
      auto_d     = 1'b0;
`ifdef SCOPE_ACQ_HYST_EN
      hyst_ok_d  = 1'b0;
`endif
    end else begin
      if (we_s) begin
        wp_d       = wp_q + ADDR_W'(1);
        prev_d     = cur_s;
        prev_vld_d = 1'b1;
      end else begin
        wp_d       = wp_q;
      end
      case (state_q)
        S_FILL: begin
          if (we_s) begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = (cnt_d == p_q) ? S_ARM : S_FILL;
          end else begin
            state_d = S_FILL;
          end
        end
        S_ARM: begin
          if (we_s && (fire_s || force_s)) begin
            trig_addr_d = wp_q;
            auto_d      = !fire_s;
            cnt_d       = '0;
            rp_d        = wp_q - p_q;
            state_d     = (post_n_s == '0) ? S_DONE : S_POST;
          end else if (we_s) begin
            tcnt_d      = (tcnt_q == '1) ? tcnt_q : tcnt_q + CNT_W'(1);
`ifdef SCOPE_ACQ_HYST_EN
            // An edge seen while not re-armed consumes the attempt.
            hyst_ok_d   = (hyst_ok_q && !(prev_vld_q && edge_s)) || beyond_s;
`endif
          end else begin
            state_d     = S_ARM;
          end
        end
        S_POST: begin
          if (we_s) begin
            cnt_d   = cnt_q + ADDR_W'(1);
            rp_d    = trig_addr_q - p_q;
            state_d = (cnt_d == post_n_s) ? S_DONE : S_POST;
          end else begin
            state_d = S_POST;
          end
        end
        S_DONE: begin
          if (i_rd_en) begin
            rd_data_d  = rd_word_s;
            rd_valid_d = 1'b1;
            rp_d       = rp_q + ADDR_W'(1);
          end else begin
            rd_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    ready_d = (state_d == S_DONE);
    busy_d  = (state_d == S_FILL) || (state_d == S_ARM) || (state_d == S_POST);
  end

  // Control and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      trig_addr_q <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      auto_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
`ifdef SCOPE_ACQ_HYST_EN
      hyst_ok_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      trig_addr_q <= trig_addr_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      auto_q      <= auto_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
`ifdef SCOPE_ACQ_HYST_EN
      hyst_ok_q   <= hyst_ok_d;
`endif
    end
  end

  // Sample RAM: one bank per channel, deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (we_s) begin
      for (int c = 0; c < NCH; c++) begin
        mem_q[c][wp_q] <= i_adc_d[c*DATA_W +: DATA_W];
      end
    end
  end

  assign o_ready     = ready_q;
  assign o_busy      = busy_q;
  assign o_auto_trig = auto_q;
  assign o_trig_addr = trig_addr_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_scope_acq.sv
// Bench for scope_acq: ramp vector table, hand-built corner sequences and a randomized
// acquisition/readout loop checked against a sample-index reference model.
module tb_scope_acq;
  localparam int DW = 8, AW = 4, NC = 2, CW = 8, DEPTH = 16, LEN = 64, SLEN = 96;

  logic          clk = 1'b0;
  logic          i_reset, i_sample_en, i_start, i_trig_edge, i_trig_mode, i_rd_en;
  logic [NC*DW-1:0] i_adc_d;
  logic [1:0]    i_trig_chan, i_rd_chan;
  logic [DW-1:0] i_trig_level;
  logic [CW-1:0] i_auto_timeout;
  logic [AW-1:0] i_pretrig;
  logic          o_ready, o_busy, o_auto_trig, o_rd_valid;
  logic [AW-1:0] o_trig_addr;
  logic [DW-1:0] o_rd_data;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] seq0 [SLEN];
  logic [7:0] seq1 [SLEN];

  typedef struct {
    bit         mode;
    bit         fall;
    logic [7:0] level;
    logic [3:0] pre;
    logic [7:0] tout;
    logic [7:0] start;
    logic [7:0] step;
    int         exp_n;
    logic [3:0] exp_addr;
    bit         exp_auto;
    logic [7:0] exp_first;
  } vec_t;
  vec_t tbl [6];

  scope_acq #(.DATA_W(DW), .ADDR_W(AW), .NCH(NC), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_sample_en(i_sample_en), .i_adc_d(i_adc_d),
    .i_start(i_start), .i_trig_chan(i_trig_chan), .i_trig_edge(i_trig_edge),
    .i_trig_level(i_trig_level), .i_trig_mode(i_trig_mode), .i_auto_timeout(i_auto_timeout),
    .i_pretrig(i_pretrig), .i_rd_en(i_rd_en), .i_rd_chan(i_rd_chan),
    .o_ready(o_ready), .o_busy(o_busy), .o_auto_trig(o_auto_trig),
    .o_trig_addr(o_trig_addr), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_acq(input bit mode, input bit fall, input logic [7:0] level,
                           input logic [3:0] pre, input logic [7:0] tout, input logic [1:0] tch);
    i_trig_mode = mode; i_trig_edge = fall; i_trig_level = level;
    i_pretrig = pre; i_auto_timeout = tout; i_trig_chan = tch;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic feed_until_ready(input int limit, output int n);
    n = 0;
    while (!o_ready && n < limit) begin
      i_sample_en = 1'b1;
      i_adc_d = {seq1[n], seq0[n]};
      tick();
      n++;
    end
    i_sample_en = 1'b0;
  endtask

  task automatic read_one(input logic [1:0] ch, input logic [7:0] exp, input string name);
    i_rd_en = 1'b1; i_rd_chan = ch;
    tick();
    i_rd_en = 1'b0;
    chk({name, "_valid"}, o_rd_valid, 1);
    chk({name, "_data"}, o_rd_data, exp);
    tick();
    chk({name, "_pulse"}, o_rd_valid, 0);
  endtask

  function automatic logic [7:0] smp(input int ch, input int idx);
    return (ch == 1) ? seq1[idx] : seq0[idx];
  endfunction

  // Reference: index of the first qualifying sample at or after the pre-trigger span.
  function automatic void model(input bit mode, input bit fall, input logic [7:0] level,
                                input int pre, input int tout, input int tc,
                                output int k, output bit forced);
    logic [7:0] cur, prv;
    bit hit;
    bit armed;
    armed = 1'b0;
    k = -1;
    forced = 1'b0;
    for (int j = pre; j < LEN && k < 0; j++) begin
      cur = smp(tc, j);
      hit = 1'b0;
      if (j > 0) begin
        prv = smp(tc, j - 1);
        hit = fall ? (prv > level && cur <= level) : (prv <= level && cur > level);
      end
`ifdef SCOPE_ACQ_HYST_EN
      hit = hit && armed;
      if (fall) armed = armed || (int'(cur) > ((int'(level) + 4 > 255) ? 255 : int'(level) + 4));
      else      armed = armed || (int'(cur) < int'(level) - 4);
`endif
      if (hit) k = j;
      else if (!mode && (j - pre) >= tout) begin
        k = j;
        forced = 1'b1;
      end
    end
  endfunction

  int n, k, need, fed, cyc, tc, rc, pre, tout;
  bit mode, fall, forced, en;
  logic [7:0] level, v;

  initial begin
    i_reset = 1'b1; i_sample_en = 1'b0; i_adc_d = '0; i_start = 1'b0; i_trig_chan = 2'd0;
    i_trig_edge = 1'b0; i_trig_level = 8'h00; i_trig_mode = 1'b0; i_auto_timeout = 8'd0;
    i_pretrig = 4'd0; i_rd_en = 1'b0; i_rd_chan = 2'd0;
    tick(); tick();
    i_reset = 1'b0;
    tick();
    chk("rst_ready", o_ready, 0); chk("rst_busy", o_busy, 0); chk("rst_auto", o_auto_trig, 0);
    chk("rst_taddr", o_trig_addr, 0); chk("rst_rdata", o_rd_data, 0); chk("rst_rvalid", o_rd_valid, 0);

    //           mode  fall level  pre   tout   start  step   n   addr  auto first
    tbl[0] = '{1'b1, 1'b0, 8'h80, 4'd4, 8'd0,  8'h70, 8'h01, 29, 4'd1,  1'b0, 8'h7D};
    tbl[1] = '{1'b0, 1'b0, 8'h80, 4'd4, 8'd5,  8'h10, 8'h00, 21, 4'd9,  1'b1, 8'h10};
    tbl[2] = '{1'b1, 1'b1, 8'h40, 4'd2, 8'd0,  8'h50, 8'hFF, 30, 4'd0,  1'b0, 8'h42};
    tbl[3] = '{1'b0, 1'b0, 8'h10, 4'd1, 8'd50, 8'h05, 8'h01, 27, 4'd12, 1'b0, 8'h10};
    tbl[4] = '{1'b1, 1'b0, 8'h20, 4'd15, 8'd0, 8'h00, 8'h01, 34, 4'd1,  1'b0, 8'h12};
    tbl[5] = '{1'b0, 1'b0, 8'h80, 4'd3, 8'd0,  8'hFF, 8'h00, 16, 4'd3,  1'b1, 8'hFF};
    for (int r = 0; r < 6; r++) begin
      v = tbl[r].start;
      for (int i = 0; i < SLEN; i++) begin
        seq0[i] = v; seq1[i] = ~v; v = v + tbl[r].step;
      end
      start_acq(tbl[r].mode, tbl[r].fall, tbl[r].level, tbl[r].pre, tbl[r].tout, 2'd0);
      feed_until_ready(90, n);
      chk($sformatf("row%0d_strobes", r), n, tbl[r].exp_n);
      chk($sformatf("row%0d_ready", r), o_ready, 1);
      chk($sformatf("row%0d_busy", r), o_busy, 0);
      chk($sformatf("row%0d_taddr", r), o_trig_addr, tbl[r].exp_addr);
      chk($sformatf("row%0d_auto", r), o_auto_trig, tbl[r].exp_auto);
      read_one(2'd0, tbl[r].exp_first, $sformatf("row%0d_rd", r));
    end

    // P=0 after a run ending at 0xFF: the first sample must not see a stale prev.
    for (int i = 0; i < SLEN; i++) begin seq0[i] = 8'h80; seq1[i] = 8'h00; end
    seq0[1] = 8'h90;
    start_acq(1'b1, 1'b1, 8'h80, 4'd0, 8'd0, 2'd0);
    feed_until_ready(90, n);
    chk("p0_strobes", n, 18); chk("p0_taddr", o_trig_addr, 2); chk("p0_auto", o_auto_trig, 0);
    read_one(2'd0, 8'h80, "p0_rd");

    // Normal mode on a flat input never completes.
    for (int i = 0; i < SLEN; i++) begin seq0[i] = 8'h10; seq1[i] = 8'h33; end
    start_acq(1'b1, 1'b0, 8'h80, 4'd2, 8'd0, 2'd0);
    feed_until_ready(90, n);
    chk("norm_strobes", n, 90); chk("norm_ready", o_ready, 0); chk("norm_busy", o_busy, 1);

    // Restart during POST.
    for (int i = 0; i < SLEN; i++) begin seq0[i] = 8'(8'h70 + i); seq1[i] = ~seq0[i]; end
    start_acq(1'b1, 1'b0, 8'h80, 4'd4, 8'd0, 2'd0);
    feed_until_ready(20, n);
    chk("post_ready", o_ready, 0);
    start_acq(1'b1, 1'b0, 8'h80, 4'd4, 8'd0, 2'd0);
    chk("restart_ready", o_ready, 0); chk("restart_busy", o_busy, 1);
    feed_until_ready(90, n);
    chk("restart_strobes", n, 29); chk("restart_taddr", o_trig_addr, 1);
    read_one(2'd1, 8'h82, "restart_rd");

    // Reset while armed, asserted together with start.
    for (int i = 0; i < SLEN; i++) begin seq0[i] = 8'h10; seq1[i] = 8'h10; end
    start_acq(1'b1, 1'b0, 8'h80, 4'd2, 8'd0, 2'd0);
    feed_until_ready(6, n);
    i_reset = 1'b1; i_start = 1'b1;
    tick();
    i_reset = 1'b0; i_start = 1'b0;
    chk("arst_ready", o_ready, 0); chk("arst_busy", o_busy, 0); chk("arst_auto", o_auto_trig, 0);
    chk("arst_taddr", o_trig_addr, 0); chk("arst_rdata", o_rd_data, 0); chk("arst_rvalid", o_rd_valid, 0);
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    chk("idle_busy", o_busy, 0); chk("idle_rvalid", o_rd_valid, 0);

`ifdef SCOPE_ACQ_HYST_EN
    // Noise straddling the level must not trigger until a sample drops below level-4.
    for (int i = 0; i < SLEN; i++) begin seq0[i] = (i % 2 == 0) ? 8'h7E : 8'h81; seq1[i] = 8'h00; end
    seq0[20] = 8'h7B;
    start_acq(1'b1, 1'b0, 8'h80, 4'd1, 8'd0, 2'd0);
    feed_until_ready(90, n);
    chk("hyst_strobes", n, 36); chk("hyst_taddr", o_trig_addr, 5);
`endif

    for (int it = 0; it < 30; it++) begin
      mode = 1'($urandom); fall = 1'($urandom); level = 8'($urandom);
      pre = $urandom_range(0, 15); tout = $urandom_range(0, 20); tc = $urandom_range(0, 3);
      for (int i = 0; i < SLEN; i++) begin seq0[i] = 8'($urandom); seq1[i] = 8'($urandom); end
      model(mode, fall, level, pre, tout, (tc == 1) ? 1 : 0, k, forced);
      need = (k < 0) ? LEN : k + DEPTH - pre;
      start_acq(mode, fall, level, 4'(pre), 8'(tout), 2'(tc));
      fed = 0; cyc = 0;
      while (fed < need && cyc < 2000) begin
        en = ($urandom_range(0, 3) != 0);
        i_sample_en = en;
        i_adc_d = en ? {seq1[fed], seq0[fed]} : 16'($urandom);
        i_rd_en = 1'($urandom); i_rd_chan = 2'($urandom);
        tick();
        cyc++;
        if (en) fed++;
        chk($sformatf("rnd%0d_busy", it), o_busy, !(k >= 0 && fed == need));
        chk($sformatf("rnd%0d_ready", it), o_ready, (k >= 0 && fed == need));
        chk($sformatf("rnd%0d_rvalid_idle", it), o_rd_valid, 0);
      end
      i_sample_en = 1'b0; i_rd_en = 1'b0;
      if (k >= 0) begin
        chk($sformatf("rnd%0d_taddr", it), o_trig_addr, k % DEPTH);
        chk($sformatf("rnd%0d_auto", it), o_auto_trig, forced);
        for (int i = 0; i < DEPTH; i++) begin
          rc = $urandom_range(0, 3);
          read_one(2'(rc), smp((rc == 1) ? 1 : 0, k - pre + i), $sformatf("rnd%0d_rd%0d", it, i));
          if ($urandom_range(0, 1) == 1) tick();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
